// File: rtl/param_memory_pkg.sv
// ---------------------------------------------------------------------------
// param_memory_pkg
//   Shared constants for param_memory: FSM state encoding and default
//   parameter values. Imported by the memory top and by anything that needs
//   to agree with its encoding.
// ---------------------------------------------------------------------------
package param_memory_pkg;

    // Two-state sweep FSM. Kept as plain 1-bit constants so the encoding is
    // fixed and visible to legacy tools that do not handle enums well.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Default parameter values for param_memory.
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INIT_VAL = 0;

endpackage : param_memory_pkg

// File: rtl/param_memory.sv
// ---------------------------------------------------------------------------
// param_memory
//   Single-port word memory (2**ADDR_W x DATA_W) that clears itself to
//   INIT_VAL with a one-word-per-cycle sweep after reset and on request.
//
//   Ports
//     clk        in   clock, all state changes on rising edge
//     rst_n      in   asynchronous active-low reset
//     req        in   access request (ignored while busy)
//     we         in   1 = write, 0 = read, qualified by req
//     addr       in   word address [ADDR_W]
//     in         in   write data [DATA_W]
//     clr        in   start a clear sweep (wins over a same-cycle req)
//     out        out  registered read data [DATA_W], holds between reads
//     out_valid  out  one-cycle pulse, cycle after an accepted read
//     busy       out  high while the clear sweep runs
//
//   The array, counter and FSM are intentionally kept in this one module so
//   that the array maps onto a single-port RAM: there is exactly one write
//   port (muxed between sweep and user write) and one synchronous read.
// ---------------------------------------------------------------------------
module param_memory
    import param_memory_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in,
    input  logic              clr,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = '1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;

    logic              w_clear;
    logic              w_idle;
    logic              w_rd;
    logic              w_wr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;

    assign w_clear = (r_state == ST_CLEAR);
    assign w_idle  = (r_state == ST_IDLE);

    // clr takes priority over a same-cycle access; nothing is accepted
    // while the sweep is running.
    assign w_rd = w_idle & req & ~we & ~clr;
    assign w_wr = w_idle & req &  we & ~clr;

    // Single write port shared by the sweep and user writes.
    assign w_mem_we   = w_clear | w_wr;
    assign w_mem_addr = w_clear ? r_cnt    : addr;
    assign w_mem_din  = w_clear ? INIT_VAL : in;

    // Array has no reset: its contents are defined only by the sweep.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // FSM, sweep counter and read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd;
            if (w_rd) begin
                r_out <= r_mem[addr];
            end

            if (w_clear) begin
                // Counter wraps naturally from LAST_ADR to 0 as we leave.
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST_ADR) begin
                    r_state <= ST_IDLE;
                end
            end else if (clr) begin
                r_state <= ST_CLEAR;
                r_cnt   <= '0;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = w_clear;

endmodule : param_memory

// File: tb/tb_param_memory.sv
// ---------------------------------------------------------------------------
// tb_param_memory
//   Two instances: A (DATA_W=8, ADDR_W=4, INIT_VAL=0) and
//   B (DATA_W=8, ADDR_W=2, INIT_VAL=0x3C). Reads push the expected word and
//   the cycle it must appear in; a monitor per instance pops on out_valid.
// ---------------------------------------------------------------------------
module tb_param_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // ---------------- instance A ----------------
    logic       a_rst_n, a_req, a_we, a_clr;
    logic [3:0] a_addr;
    logic [7:0] a_in, a_out;
    logic       a_out_valid, a_busy;

    param_memory #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'h00)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .req(a_req), .we(a_we), .addr(a_addr),
        .in(a_in), .clr(a_clr), .out(a_out), .out_valid(a_out_valid),
        .busy(a_busy)
    );

    // ---------------- instance B ----------------
    logic       b_rst_n, b_req, b_we, b_clr;
    logic [1:0] b_addr;
    logic [7:0] b_in, b_out;
    logic       b_out_valid, b_busy;

    param_memory #(.DATA_W(8), .ADDR_W(2), .INIT_VAL(8'h3C)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .req(b_req), .we(b_we), .addr(b_addr),
        .in(b_in), .clr(b_clr), .out(b_out), .out_valid(b_out_valid),
        .busy(b_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        #1;
        if (a_out_valid === 1'b1) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_valid actual out=%0h at cyc %0d expected no valid", a_out, cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (a_out !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL a_read actual=%0h@%0d expected=%0h@%0d", a_out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (b_out_valid === 1'b1) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL b_unexpected_valid actual out=%0h at cyc %0d expected no valid", b_out, cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (b_out !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL b_read actual=%0h@%0d expected=%0h@%0d", b_out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic a_write(input logic [3:0] a, input logic [7:0] d);
        a_req = 1'b1; a_we = 1'b1; a_addr = a; a_in = d;
        @(negedge clk);
        a_req = 1'b0; a_we = 1'b0;
    endtask

    task automatic a_read(input logic [3:0] a, input logic [7:0] exp);
        a_req = 1'b1; a_we = 1'b0; a_addr = a;
        qa.push_back('{data: exp, cyc: cyc + 1});
        @(negedge clk);
        a_req = 1'b0;
    endtask

    task automatic b_read(input logic [1:0] a, input logic [7:0] exp);
        b_req = 1'b1; b_we = 1'b0; b_addr = a;
        qb.push_back('{data: exp, cyc: cyc + 1});
        @(negedge clk);
        b_req = 1'b0;
    endtask

    // Count edges until A leaves CLEAR. Optionally drive writes, reads and
    // a clr during the sweep; none of them may have any effect.
    task automatic a_sweep(input string name, input bit junk);
        int n;
        n = 0;
        chk({name, "_busy_start"}, int'(a_busy), 1);
        while (a_busy === 1'b1 && n < 64) begin
            a_req = 1'b0; a_we = 1'b0; a_clr = 1'b0;
            if (junk) begin
                if (n < 3) begin
                    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_in = 8'hFF;
                end else if (n < 5) begin
                    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
                end else if (n == 8) begin
                    a_clr = 1'b1;
                end
            end
            @(negedge clk);
            n++;
        end
        a_req = 1'b0; a_we = 1'b0; a_clr = 1'b0;
        chk({name, "_len"}, n, 16);
        chk({name, "_cnt_wrap"}, int'(dut_a.r_cnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_clr = 1'b0;
        a_addr = '0; a_in = '0;
        b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_clr = 1'b0;
        b_addr = '0; b_in = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("a_rst_busy",  int'(a_busy), 1);
        chk("a_rst_out",   int'(a_out), 0);
        chk("a_rst_valid", int'(a_out_valid), 0);
        chk("a_rst_cnt",   int'(dut_a.r_cnt), 0);
        chk("b_rst_busy",  int'(b_busy), 1);

        // Initial sweep and all-zero readback.
        a_rst_n = 1'b1;
        a_sweep("a_init", 1'b0);
        for (int i = 0; i < 16; i++) a_read(4'(i), 8'h00);
        repeat (2) @(negedge clk);

        // Write then read-next-cycle; out holds afterwards.
        a_write(4'd3, 8'hA5);
        a_read(4'd3, 8'hA5);
        repeat (3) @(negedge clk);
        chk("a_out_hold",   int'(a_out), 8'hA5);
        chk("a_valid_idle", int'(a_out_valid), 0);

        // clr and write in the same cycle: write dropped.
        a_clr = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_in = 8'h11;
        @(negedge clk);
        a_clr = 1'b0; a_req = 1'b0; a_we = 1'b0;
        chk("a_clr_out_hold", int'(a_out), 8'hA5);
        a_sweep("a_clr", 1'b0);
        a_read(4'd2, 8'h00);
        a_read(4'd3, 8'h00);

        // Requests and a repeated clr during busy are ignored.
        a_write(4'd5, 8'h5A);
        a_read(4'd5, 8'h5A);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        a_sweep("a_busyreq", 1'b1);
        a_read(4'd5, 8'h00);

        // Reset at sweep cycle 7 aborts; fresh full sweep follows.
        a_write(4'd9, 8'h77);
        a_read(4'd9, 8'h77);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        repeat (7) @(negedge clk);
        chk("a_mid_cnt7", int'(dut_a.r_cnt), 7);
        a_rst_n = 1'b0;
        #1;
        chk("a_mid_rst_busy",  int'(a_busy), 1);
        chk("a_mid_rst_cnt",   int'(dut_a.r_cnt), 0);
        chk("a_mid_rst_out",   int'(a_out), 0);
        chk("a_mid_rst_valid", int'(a_out_valid), 0);
        repeat (2) @(negedge clk);
        chk("a_mid_rst_hold_busy", int'(a_busy), 1);
        a_rst_n = 1'b1;
        a_sweep("a_rerun", 1'b0);
        a_read(4'd9, 8'h00);

        // Instance B: 4-word sweep to 0x3C.
        b_rst_n = 1'b1;
        n = 0;
        while (b_busy === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("b_sweep_len", n, 4);
        chk("b_cnt_wrap", int'(dut_b.r_cnt), 0);
        for (int i = 0; i < 4; i++) b_read(2'(i), 8'h3C);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_param_memory

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 8, meaning word width in bits.
REQ-002 The module SHALL expose parameter ADDR_W, default 8, meaning address width, with depth 2**ADDR_W words.
REQ-003 The module SHALL expose parameter INIT_VAL, default 0, meaning the value written to every word by a clear sweep.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  access request, sampled each rising clk edge.
REQ-007 we  input  1  1 = write, 0 = read; qualified by req.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 in  input  DATA_W  write data.
REQ-010 clr  input  1  request to re-clear the whole array.
REQ-011 out  output  DATA_W  registered read data.
REQ-012 out_valid  output  1  one-cycle pulse marking out as fresh read data.
REQ-013 busy  output  1  high while a clear sweep runs; requests are not accepted.

Function
REQ-014 The FSM SHALL have two states: CLEAR and IDLE.
REQ-015 In CLEAR, each cycle SHALL write INIT_VAL to mem[cnt] and increment cnt; at cnt = 2**ADDR_W-1, it SHALL write that word and go to IDLE with cnt wrapped to 0.
REQ-016 A full sweep SHALL take exactly 2**ADDR_W cycles; busy SHALL be 1 exactly in CLEAR.
REQ-017 In IDLE with clr=1, the FSM SHALL enter CLEAR with cnt=0 on the next edge; any req in that cycle SHALL be dropped (clr wins).
REQ-018 clr SHALL be ignored while in CLEAR; the running sweep SHALL continue and not restart.
REQ-019 In IDLE with req=1, we=1 and clr=0, mem[addr] SHALL take in at the edge; out and out_valid SHALL be unaffected.
REQ-020 In IDLE with req=1, we=0 and clr=0, out SHALL equal mem[addr] and out_valid SHALL be 1 in the following cycle; latency is 1 cycle.
REQ-021 out_valid SHALL be 0 in every cycle not following an accepted read; out SHALL hold its last value.
REQ-022 A read issued in the cycle after a write to the same address SHALL return the newly written data.
REQ-023 req while busy=1 SHALL have no effect on memory, out or out_valid.
REQ-024 Addresses SHALL be unsigned; no out-of-range case exists.

Reset
REQ-025 On rst_n=0, the module SHALL set state=CLEAR, cnt=0, out=0, out_valid=0 and busy=1 asynchronously.
REQ-026 The memory array SHALL NOT be reset asynchronously; it SHALL be initialised only by the sweep that begins at the first edge after rst_n rises.
REQ-027 Reset asserted mid-sweep or mid-access SHALL abort the sweep or access, and a fresh full sweep SHALL follow release.

Structure
REQ-028 The state encoding (CLEAR, IDLE) and default parameter constants SHALL live in the shared package param_memory_pkg.
REQ-029 The array, sweep counter and FSM SHALL live in one module with no sub-module, so that synthesis can infer a single-port RAM.

Verification
REQ-030 DATA_W=8, ADDR_W=4: release reset -> busy=1 for exactly 16 cycles, then 0; reading all 16 addresses returns 0x00.
REQ-031 Write 0xA5 to addr 3, then read addr 3 the next cycle -> out=0xA5 with out_valid=1 exactly one cycle later.
REQ-032 In IDLE, assert clr and req/we writing 0x11 to addr 2 in the same cycle -> write dropped, 16-cycle sweep, addr 2 reads 0x00.
REQ-033 Assert req during busy (write 0xFF to addr 5) -> after the sweep, addr 5 reads INIT_VAL; out_valid stays 0 throughout busy.
REQ-034 Assert rst_n=0 at sweep cycle 7 -> busy remains 1, cnt returns to 0, and the full 16-cycle sweep reruns after release.
REQ-035 INIT_VAL=0x3C, ADDR_W=2: after reset, read addrs 0..3 -> each returns 0x3C; cnt wraps 3->0 on entering IDLE.
